// File: rtl/encoder_4_2_sync.sv
// Debounced 4-to-2 priority encoder. req[3] has the highest priority and gives code 00; req[0] gives code 11.
// Latency: a stable request is presented DB_CYCLES edges after capture, counting the capture edge.
//   Without ENCODER_4_2_SYNC_DEBOUNCE_EN, the code is presented on the capture edge itself.
// Handshake: the code stays held until ack arrives; after that, req must return to 0 before a new capture.
//   Define the macro ENCODER_4_2_SYNC_DEBOUNCE_EN to build the DEBOUNCE state and its counter.
module encoder_4_2_sync #(
    parameter int DB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] req,
    input  logic       ack,
    output logic [1:0] code,
    output logic       valid,
    output logic       multi
);

    // Reject illegal debounce depths at elaboration. The counter is 4 bits wide.
    if (DB_CYCLES < 1 || DB_CYCLES > 15) begin : g_db_range
        $error("encoder_4_2_sync: DB_CYCLES must be in 1..15");
    end

`ifdef ENCODER_4_2_SYNC_DEBOUNCE_EN
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd2,
        RELEASE = 2'd3
    } state_t;
`endif

    state_t     state, state_n;
    logic [1:0] code_n;
    logic       valid_n;
    logic       multi_n;

    // Fixed priority: the highest-numbered active line wins and maps to the lowest code.
    function automatic logic [1:0] enc_code(input logic [3:0] r);
        if (r[3])      return 2'b00;
        else if (r[2]) return 2'b01;
        else if (r[1]) return 2'b10;
        else           return 2'b11;
    endfunction

    // The clear-lowest-set-bit trick leaves a nonzero result when more than one line is set.
    function automatic logic is_multi(input logic [3:0] r);
        return (r & (r - 4'd1)) != 4'd0;
    endfunction

`ifdef ENCODER_4_2_SYNC_DEBOUNCE_EN
    localparam logic [3:0] DB_TARGET = 4'(DB_CYCLES);

    logic [3:0] snapshot, snapshot_n;
    logic [3:0] count, count_n;
    logic [3:0] count_inc;

    // The counter saturates at 15, so a long stable request can never wrap it back to a low value.
    assign count_inc = (count == 4'hF) ? count : count + 4'd1;
`endif

    // Next-state and next-output logic. Every register holds its value unless a branch loads it.
    always_comb begin
        state_n = state;
        code_n  = code;
        valid_n = valid;
        multi_n = multi;
`ifdef ENCODER_4_2_SYNC_DEBOUNCE_EN
        snapshot_n = snapshot;
        count_n    = count;
`endif
        case (state)
            IDLE: begin
                if (en && req != 4'd0) begin
`ifdef ENCODER_4_2_SYNC_DEBOUNCE_EN
                    snapshot_n = req;
                    count_n    = 4'd1;
                    // With a one-cycle debounce, the capture edge is also the presenting edge.
                    if (DB_TARGET <= 4'd1) begin
                        state_n = HOLD;
                        code_n  = enc_code(req);
                        multi_n = is_multi(req);
                        valid_n = 1'b1;
                    end else begin
                        state_n = DEBOUNCE;
                    end
`else
                    state_n = HOLD;
                    code_n  = enc_code(req);
                    multi_n = is_multi(req);
                    valid_n = 1'b1;
`endif
                end
            end
`ifdef ENCODER_4_2_SYNC_DEBOUNCE_EN
            DEBOUNCE: begin
                if (!en || req == 4'd0) begin
                    state_n = IDLE;
                end else if (req == snapshot) begin
                    count_n = count_inc;
                    if (count_inc >= DB_TARGET) begin
                        state_n = HOLD;
                        code_n  = enc_code(snapshot);
                        multi_n = is_multi(snapshot);
                        valid_n = 1'b1;
                    end
                end else begin
                    // The request pattern changed but is still nonzero, so restart debouncing on the new pattern.
                    snapshot_n = req;
                    count_n    = 4'd1;
                end
            end
`endif
            HOLD: begin
                if (ack) begin
                    state_n = RELEASE;
                    valid_n = 1'b0;
                end
            end
            RELEASE: begin
                // Wait for all request lines to drop, so a request that is still held cannot trigger again.
                if (req == 4'd0) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers. Synchronous reset overrides all other inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            code  <= 2'b00;
            valid <= 1'b0;
            multi <= 1'b0;
`ifdef ENCODER_4_2_SYNC_DEBOUNCE_EN
            snapshot <= 4'd0;
            count    <= 4'd0;
`endif
        end else begin
            state <= state_n;
            code  <= code_n;
            valid <= valid_n;
            multi <= multi_n;
`ifdef ENCODER_4_2_SYNC_DEBOUNCE_EN
            snapshot <= snapshot_n;
            count    <= count_n;
`endif
        end
    end

endmodule

// File: tb/tb_encoder_4_2_sync.sv
// Bench for encoder_4_2_sync with DB_CYCLES at its default of 4.
// Each table row is driven for one cycle, and its expected outputs pass through a scoreboard queue.
// The expected values follow whichever build is compiled: ENCODER_4_2_SYNC_DEBOUNCE_EN defined or not.
module tb_encoder_4_2_sync;

    logic       clk;
    logic       reset;
    logic       en;
    logic [3:0] req;
    logic       ack;
    logic [1:0] code;
    logic       valid;
    logic       multi;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] req;
        logic       ack;
        logic       v;
        logic [1:0] c;
        logic       m;
    } vec_t;

    typedef struct {
        int         row;
        logic       v;
        logic [1:0] c;
        logic       m;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    encoder_4_2_sync #(.DB_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .req   (req),
        .ack   (ack),
        .code  (code),
        .valid (valid),
        .multi (multi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bounds the whole run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required<200000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic add(input logic r, input logic e, input logic [3:0] q, input logic a,
                       input logic v, input logic [1:0] c, input logic m);
        vec_t t;
        t.rst = r; t.en = e; t.req = q; t.ack = a;
        t.v = v; t.c = c; t.m = m;
        tbl.push_back(t);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    int  lat;
    bit  found;
    int  exp_lat;

    initial begin
        reset = 1'b0; en = 1'b0; req = 4'd0; ack = 1'b0;

`ifdef ENCODER_4_2_SYNC_DEBOUNCE_EN
        exp_lat = 4;
        //   rst en req      ack   v  code  m
        add(1, 1, 4'b1111, 1,   0, 2'b00, 0);  // 0: the reset edge wins over all other inputs
        add(0, 1, 4'b0100, 0,   0, 2'b00, 0);  // 1: capture edge
        add(0, 1, 4'b0100, 0,   0, 2'b00, 0);  // 2
        add(0, 1, 4'b0100, 1,   0, 2'b00, 0);  // 3: ack in DEBOUNCE is ignored
        add(0, 1, 4'b0100, 0,   1, 2'b01, 0);  // 4: 4th edge, presented
        add(0, 1, 4'b0100, 1,   0, 2'b01, 0);  // 5: ack to RELEASE
        add(0, 1, 4'b0100, 0,   0, 2'b01, 0);  // 6: held line gives no re-trigger
        add(0, 1, 4'b0000, 0,   0, 2'b01, 0);  // 7: to IDLE
        add(0, 1, 4'b1001, 0,   0, 2'b01, 0);  // 8
        add(0, 1, 4'b1001, 0,   0, 2'b01, 0);  // 9
        add(0, 1, 4'b1001, 0,   0, 2'b01, 0);  // 10
        add(0, 1, 4'b1001, 0,   1, 2'b00, 1);  // 11: multi
        add(0, 1, 4'b1001, 1,   0, 2'b00, 1);  // 12
        add(0, 1, 4'b1001, 0,   0, 2'b00, 1);  // 13
        add(0, 1, 4'b1001, 0,   0, 2'b00, 1);  // 14
        add(0, 1, 4'b0000, 0,   0, 2'b00, 1);  // 15: to IDLE
        add(0, 1, 4'b0010, 0,   0, 2'b00, 1);  // 16: bounce start
        add(0, 1, 4'b0010, 0,   0, 2'b00, 1);  // 17
        add(0, 1, 4'b0000, 0,   0, 2'b00, 1);  // 18: drop, back to IDLE
        add(0, 1, 4'b0010, 0,   0, 2'b00, 1);  // 19: second capture
        add(0, 1, 4'b0010, 0,   0, 2'b00, 1);  // 20
        add(0, 1, 4'b0010, 0,   0, 2'b00, 1);  // 21
        add(0, 1, 4'b0010, 0,   1, 2'b10, 0);  // 22
        add(0, 0, 4'b1000, 0,   1, 2'b10, 0);  // 23: HOLD ignores req and en
        add(0, 0, 4'b1000, 1,   0, 2'b10, 0);  // 24
        add(0, 1, 4'b0000, 0,   0, 2'b10, 0);  // 25
        add(0, 1, 4'b0001, 0,   0, 2'b10, 0);  // 26: capture
        add(0, 1, 4'b0001, 0,   0, 2'b10, 0);  // 27
        add(0, 1, 4'b0001, 0,   0, 2'b10, 0);  // 28: count=3
        add(1, 1, 4'b0001, 0,   0, 2'b00, 0);  // 29: reset mid-DEBOUNCE
        add(0, 1, 4'b0001, 0,   0, 2'b00, 0);  // 30: new capture
        add(0, 1, 4'b0001, 0,   0, 2'b00, 0);  // 31
        add(0, 1, 4'b0001, 0,   0, 2'b00, 0);  // 32
        add(0, 1, 4'b0001, 0,   1, 2'b11, 0);  // 33: full latency after reset
        add(0, 0, 4'b1000, 0,   1, 2'b11, 0);  // 34: code 11 held
        add(0, 1, 4'b1000, 0,   1, 2'b11, 0);  // 35
        add(0, 1, 4'b1000, 1,   0, 2'b11, 0);  // 36
        add(0, 1, 4'b0000, 0,   0, 2'b11, 0);  // 37
        add(0, 1, 4'b0000, 1,   0, 2'b11, 0);  // 38: ack in IDLE is ignored
        add(0, 1, 4'b0011, 0,   0, 2'b11, 0);  // 39: capture 0011
        add(0, 1, 4'b0010, 0,   0, 2'b11, 0);  // 40: re-capture 0010
        add(0, 1, 4'b0010, 0,   0, 2'b11, 0);  // 41
        add(0, 1, 4'b0010, 0,   0, 2'b11, 0);  // 42
        add(0, 1, 4'b0010, 0,   1, 2'b10, 0);  // 43
        add(0, 1, 4'b0010, 1,   0, 2'b10, 0);  // 44
        add(0, 1, 4'b0000, 0,   0, 2'b10, 0);  // 45
        add(0, 1, 4'b0100, 0,   0, 2'b10, 0);  // 46: capture
        add(0, 0, 4'b0100, 0,   0, 2'b10, 0);  // 47: en=0 aborts
        add(0, 1, 4'b0100, 0,   0, 2'b10, 0);  // 48: capture again
        add(0, 1, 4'b0100, 0,   0, 2'b10, 0);  // 49
        add(0, 1, 4'b0100, 0,   0, 2'b10, 0);  // 50
        add(0, 1, 4'b0100, 0,   1, 2'b01, 0);  // 51
        add(0, 1, 4'b0000, 1,   0, 2'b01, 0);  // 52
        add(0, 1, 4'b0000, 0,   0, 2'b01, 0);  // 53
`else
        exp_lat = 1;
        //   rst en req      ack   v  code  m
        add(1, 1, 4'b1111, 1,   0, 2'b00, 0);  // 0: the reset edge wins over all other inputs
        add(0, 1, 4'b0001, 0,   1, 2'b11, 0);  // 1: presented on the first edge
        add(0, 1, 4'b0001, 0,   1, 2'b11, 0);  // 2
        add(0, 0, 4'b1000, 0,   1, 2'b11, 0);  // 3: HOLD ignores req and en
        add(0, 0, 4'b1000, 1,   0, 2'b11, 0);  // 4: ack to RELEASE
        add(0, 1, 4'b1000, 0,   0, 2'b11, 0);  // 5: held line gives no re-trigger
        add(0, 1, 4'b0000, 0,   0, 2'b11, 0);  // 6: to IDLE
        add(0, 0, 4'b0010, 0,   0, 2'b11, 0);  // 7: en=0 in IDLE
        add(0, 1, 4'b1001, 0,   1, 2'b00, 1);  // 8: multi
        add(0, 1, 4'b0000, 1,   0, 2'b00, 1);  // 9
        add(0, 1, 4'b0000, 0,   0, 2'b00, 1);  // 10
        add(0, 0, 4'b0000, 1,   0, 2'b00, 1);  // 11: ack in IDLE is ignored
        add(0, 1, 4'b0110, 1,   1, 2'b01, 1);  // 12: ack not sampled in IDLE
        add(1, 1, 4'b0110, 0,   0, 2'b00, 0);  // 13: reset in HOLD
        add(0, 1, 4'b0110, 0,   1, 2'b01, 1);  // 14
        add(0, 1, 4'b0100, 1,   0, 2'b01, 1);  // 15
        add(0, 1, 4'b0100, 0,   0, 2'b01, 1);  // 16
        add(0, 1, 4'b0111, 0,   0, 2'b01, 1);  // 17
        add(0, 1, 4'b0000, 0,   0, 2'b01, 1);  // 18
        add(0, 1, 4'b1111, 0,   1, 2'b00, 1);  // 19
        add(0, 1, 4'b1111, 1,   0, 2'b00, 1);  // 20
        add(0, 1, 4'b0000, 0,   0, 2'b00, 1);  // 21
        add(0, 1, 4'b0100, 0,   1, 2'b01, 0);  // 22
        add(0, 1, 4'b0000, 1,   0, 2'b01, 0);  // 23
        add(0, 1, 4'b0000, 0,   0, 2'b01, 0);  // 24
`endif

        // Table-driven part: drive on the falling edge, check 1 time unit after the rising edge.
        for (int i = 0; i < tbl.size(); i++) begin
            exp_t e;
            @(negedge clk);
            reset = tbl[i].rst; en = tbl[i].en; req = tbl[i].req; ack = tbl[i].ack;
            e.row = i; e.v = tbl[i].v; e.c = tbl[i].c; e.m = tbl[i].m;
            sb.push_back(e);
            @(posedge clk);
            #1;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_empty: row %0d has no expected entry", i);
            end else begin
                exp_t x;
                x = sb.pop_front();
                if (valid !== x.v || code !== x.c || multi !== x.m) begin
                    bad++;
                    $display("FAIL row %0d: got valid=%b code=%b multi=%b, expected valid=%b code=%b multi=%b",
                             x.row, valid, code, multi, x.v, x.c, x.m);
                end
            end
        end

        // Hand-written sequence: measure capture-to-valid latency with a bounded wait.
        @(negedge clk);
        reset = 1'b1; en = 1'b0; req = 4'd0; ack = 1'b0;
        @(negedge clk);
        reset = 1'b0; en = 1'b1; req = 4'b0100;
        lat = 0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (valid === 1'b1) found = 1'b1;
        end
        check_int("latency_valid_seen", int'(found), 1);
        check_int("latency_edges", lat, exp_lat);
        check_int("latency_code", int'(code), 1);
        check_int("latency_multi", int'(multi), 0);

        // Acknowledge and confirm that valid drops on the very next edge.
        @(negedge clk);
        ack = 1'b1;
        @(posedge clk);
        #1;
        check_int("ack_drop_valid", int'(valid), 0);
        @(negedge clk);
        ack = 1'b0; req = 4'd0;
        @(posedge clk);
        #1;
        check_int("idle_after_release_valid", int'(valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
